// File: rtl/color_sensor_emulator.sv
// Responder-side stand-in for a TCS3200-style light-to-frequency sensor: emits a
// 50% duty square wave whose half-period comes from per-filter brightness registers.
module color_sensor_emulator #(
  parameter int PERIOD_W      = 24,
  parameter int SETTLE_CYCLES = 1000,
  parameter int RED_HP        = 250,
  parameter int BLUE_HP       = 200,
  parameter int GREEN_HP      = 300,
  parameter int CLEAR_HP      = 80
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_scale,
  input  logic [1:0]          i_filter,
  input  logic                i_cfgWe,
  input  logic [1:0]          i_cfgSel,
  input  logic [PERIOD_W-1:0] i_cfgData,
  output logic                o_sensorFreq,
  output logic                o_settling,
  output logic                o_run
);

  localparam int EW = PERIOD_W + 6;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] F_RED   = 2'b00;
  localparam logic [1:0] F_BLUE  = 2'b01;
  localparam logic [1:0] F_CLEAR = 2'b10;
  localparam logic [1:0] F_GREEN = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_filterQ;
  logic [1:0]          r_scaleQ;
  logic [PERIOD_W-1:0] r_hp [4];
  logic [SW-1:0]       r_settleCnt;
  logic [EW-1:0]       r_halfCnt;
  logic [EW-1:0]       r_hpEff;
  logic                r_freq;

  state_t              w_stateNext;
  logic [SW-1:0]       w_settleNext;
  logic [EW-1:0]       w_halfNext;
  logic [EW-1:0]       w_hpEffNext;
  logic                w_freqNext;
  logic                w_change;
  logic [EW-1:0]       w_hpExt;
  logic [EW-1:0]       w_hpScaled;

  assign w_change = ({i_filter, i_scale} != {r_filterQ, r_scaleQ});
  assign w_hpExt  = {6'b0, r_hp[r_filterQ]};

  // Scale factors 1/5/50 built from shifts; the 6 extra bits cover the x50 case.
  always_comb begin
    w_hpScaled = '0;
    case (r_scaleQ)
      2'b11:   w_hpScaled = w_hpExt;
      2'b10:   w_hpScaled = (w_hpExt << 2) + w_hpExt;
      2'b01:   w_hpScaled = (w_hpExt << 5) + (w_hpExt << 4) + (w_hpExt << 1);
      default: w_hpScaled = '0;
    endcase
  end

  always_comb begin
    w_stateNext  = r_state;
    w_settleNext = r_settleCnt;
    w_halfNext   = r_halfCnt;
    w_hpEffNext  = r_hpEff;
    w_freqNext   = r_freq;
    if (i_scale == 2'b00) begin
      w_stateNext  = ST_OFF;
      w_settleNext = '0;
      w_halfNext   = '0;
      w_freqNext   = 1'b0;
    end else if (w_change) begin
      w_stateNext  = ST_SETTLE;
      w_settleNext = '0;
      w_halfNext   = '0;
      w_freqNext   = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_stateNext  = ST_SETTLE;
          w_settleNext = '0;
          w_halfNext   = '0;
          w_freqNext   = 1'b0;
        end
        ST_SETTLE: begin
          w_freqNext = 1'b0;
          if (r_settleCnt == SW'(SETTLE_CYCLES - 1)) begin
            w_stateNext = ST_RUN;
            w_halfNext  = '0;
            w_hpEffNext = w_hpScaled;
          end else begin
            w_settleNext = r_settleCnt + SW'(1);
          end
        end
        ST_RUN: begin
          if (r_hpEff == '0) begin
            // Dark channel: poll the register so a fresh write counts from the next edge.
            w_freqNext = 1'b0;
            w_halfNext = '0;
            if (w_hpScaled != '0) begin
              w_hpEffNext = w_hpScaled;
              if (w_hpScaled == EW'(1)) w_freqNext = 1'b1;
              else                      w_halfNext = EW'(1);
            end
          end else if (r_halfCnt == r_hpEff - EW'(1)) begin
            w_halfNext  = '0;
            w_hpEffNext = w_hpScaled;
            w_freqNext  = (w_hpScaled == '0) ? 1'b0 : ~r_freq;
          end else begin
            w_halfNext = r_halfCnt + EW'(1);
          end
        end
        default: begin
          w_stateNext  = ST_SETTLE;
          w_settleNext = '0;
          w_halfNext   = '0;
          w_freqNext   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_filterQ <= i_filter;
    r_scaleQ  <= i_scale;
    if (i_reset) begin
      r_state        <= (i_scale == 2'b00) ? ST_OFF : ST_SETTLE;
      r_settleCnt    <= '0;
      r_halfCnt      <= '0;
      r_hpEff        <= '0;
      r_freq         <= 1'b0;
      r_hp[F_RED]    <= PERIOD_W'(RED_HP);
      r_hp[F_BLUE]   <= PERIOD_W'(BLUE_HP);
      r_hp[F_CLEAR]  <= PERIOD_W'(CLEAR_HP);
      r_hp[F_GREEN]  <= PERIOD_W'(GREEN_HP);
    end else begin
      r_state     <= w_stateNext;
      r_settleCnt <= w_settleNext;
      r_halfCnt   <= w_halfNext;
      r_hpEff     <= w_hpEffNext;
      r_freq      <= w_freqNext;
      if (i_cfgWe) r_hp[i_cfgSel] <= i_cfgData;
    end
  end

  assign o_sensorFreq = r_freq;
  assign o_settling   = (r_state == ST_SETTLE);
  assign o_run        = (r_state == ST_RUN);

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator with SETTLE_CYCLES=8; edge times are
// hand-computed from the settle length and the channel half-periods.
module tb_color_sensor_emulator;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    scale;
  logic [1:0]    filter;
  logic          cfgWe;
  logic [1:0]    cfgSel;
  logic [PW-1:0] cfgData;
  logic          sensorFreq;
  logic          settling;
  logic          run;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  color_sensor_emulator #(
    .PERIOD_W(PW),
    .SETTLE_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_scale(scale),
    .i_filter(filter),
    .i_cfgWe(cfgWe),
    .i_cfgSel(cfgSel),
    .i_cfgData(cfgData),
    .o_sensorFreq(sensorFreq),
    .o_settling(settling),
    .o_run(run)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge when read at a negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] f, input logic [1:0] s);
    filter = f;
    scale  = s;
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [PW-1:0] data);
    cfgWe   = 1'b1;
    cfgSel  = sel;
    cfgData = data;
    @(negedge clk);
    cfgWe   = 1'b0;
  endtask

  // Returns the edge number at which sensorFreq first shows lvl, or -1 on timeout.
  task automatic waitLevel(input logic lvl, input int bound, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (sensorFreq == lvl) begin
        at = cyc;
        found = 1'b1;
      end
    end
  endtask

  task automatic checkState(input string tag, input logic f, input logic s, input logic r);
    checkOutput({tag, " freq"}, int'(sensorFreq), int'(f));
    checkOutput({tag, " settling"}, int'(settling), int'(s));
    checkOutput({tag, " run"}, int'(run), int'(r));
  endtask

  initial begin
    int base, at, t, rises;
    logic prev;
    reset = 1'b0; scale = 2'b11; filter = 2'b00;
    cfgWe = 1'b0; cfgSel = 2'b00; cfgData = '0;

    // 1: reset, red at full scale
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    base = cyc;
    checkState("reset", 1'b0, 1'b1, 1'b0);
    stepCycles(7);
    checkState("settle end", 1'b0, 1'b1, 1'b0);
    stepCycles(1);
    checkState("run entry", 1'b0, 1'b0, 1'b1);
    waitLevel(1'b1, 400, at); checkOutput("red first rise", at, base + 258); t = at;
    waitLevel(1'b0, 400, at); checkOutput("red high time", at, t + 250);
    waitLevel(1'b1, 400, at); checkOutput("red period", at, t + 500);
    rises = 0; prev = sensorFreq;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sensorFreq && !prev) rises++;
      prev = sensorFreq;
    end
    checkOutput("red rises in 5000", rises, 10);

    // 2: filter change mid-high, then a second change restarts settling
    stepCycles(100);
    applyStimulus(2'b01, 2'b11);
    stepCycles(1); base = cyc;
    checkState("change drop", 1'b0, 1'b1, 1'b0);
    stepCycles(4);
    applyStimulus(2'b10, 2'b11);
    stepCycles(1); t = cyc;
    stepCycles(3);
    checkOutput("settle restarted", int'(settling), 1);
    checkOutput("restart cycle", cyc, base + 8);
    stepCycles(4);
    checkOutput("clear settle last", int'(settling), 1);
    stepCycles(1);
    checkOutput("clear run", int'(run), 1);
    waitLevel(1'b1, 200, at); checkOutput("clear first rise", at, t + 88); t = at;
    waitLevel(1'b0, 200, at); checkOutput("clear high time", at, t + 80);
    waitLevel(1'b1, 200, at); checkOutput("clear period", at, t + 160);

    // 3: blue at 20% and 2%, then power-down and recovery
    applyStimulus(2'b01, 2'b10); base = cyc + 1;
    waitLevel(1'b1, 1200, at); checkOutput("blue20 first rise", at, base + 1008); t = at;
    waitLevel(1'b0, 1200, at); checkOutput("blue20 high time", at, t + 1000);
    waitLevel(1'b1, 1200, at); checkOutput("blue20 period", at, t + 2000);
    applyStimulus(2'b01, 2'b01); base = cyc + 1;
    waitLevel(1'b1, 11000, at); checkOutput("blue2 first rise", at, base + 10008); t = at;
    waitLevel(1'b0, 11000, at); checkOutput("blue2 high time", at, t + 10000);
    waitLevel(1'b1, 11000, at); checkOutput("blue2 period", at, t + 20000);
    applyStimulus(2'b01, 2'b00);
    stepCycles(1);
    checkState("power down", 1'b0, 1'b0, 1'b0);
    stepCycles(3);
    checkState("off held", 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11); base = cyc + 1;
    stepCycles(1);
    checkState("wake settle", 1'b0, 1'b1, 1'b0);
    waitLevel(1'b1, 300, at); checkOutput("blue wake rise", at, base + 208); t = at;
    waitLevel(1'b0, 300, at);
    waitLevel(1'b1, 500, at); checkOutput("blue period", at, t + 400);

    // 4: green write landing exactly on a toggle edge
    applyStimulus(2'b11, 2'b11); base = cyc + 1;
    waitLevel(1'b1, 400, at); checkOutput("green first rise", at, base + 308); t = at;
    stepCycles(299);
    cfgWrite(2'b11, PW'(40));
    checkOutput("green toggle at write", int'(sensorFreq), 0);
    waitLevel(1'b1, 400, at); checkOutput("green old half kept", at, t + 600);
    waitLevel(1'b0, 100, at); checkOutput("green new half", at, t + 640);
    waitLevel(1'b1, 100, at); checkOutput("green new period", at, t + 680);

    // 5: red dark, then re-lit
    applyStimulus(2'b00, 2'b11); base = cyc + 1;
    waitLevel(1'b1, 400, at); checkOutput("red relock rise", at, base + 258); t = at;
    stepCycles(100);
    cfgWrite(2'b00, '0);
    waitLevel(1'b0, 300, at); checkOutput("red dark fall", at, t + 250);
    waitLevel(1'b1, 300, at); checkOutput("red dark held", at, -1);
    base = cyc + 1;
    cfgWrite(2'b00, PW'(10));
    waitLevel(1'b1, 50, at); checkOutput("red relit rise", at, base + 10); t = at;
    waitLevel(1'b0, 50, at); checkOutput("red relit fall", at, t + 10);
    waitLevel(1'b1, 50, at); checkOutput("red relit period", at, t + 20);

    // 6: one-cycle reset mid-high with a write that must be ignored
    stepCycles(3);
    reset = 1'b1; cfgWe = 1'b1; cfgSel = 2'b11; cfgData = PW'(5);
    stepCycles(1); base = cyc;
    reset = 1'b0; cfgWe = 1'b0;
    checkState("mid reset", 1'b0, 1'b1, 1'b0);
    waitLevel(1'b1, 400, at); checkOutput("post reset rise", at, base + 258); t = at;
    waitLevel(1'b0, 400, at);
    waitLevel(1'b1, 600, at); checkOutput("post reset red period", at, t + 500);
    applyStimulus(2'b11, 2'b11); base = cyc + 1;
    waitLevel(1'b1, 400, at); checkOutput("green default rise", at, base + 308); t = at;
    waitLevel(1'b0, 400, at); checkOutput("green default half", at, t + 300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
Responder-side model of the TCS3200-style light-to-frequency sensor, synthesizable for hardware-in-the-loop rover testing.
- Accepts the same filter-select (S2/S3) and frequency-scale (S0/S1) lines the color sensor reader drives.
- Outputs a square wave whose period is set by a programmable per-channel brightness register.
- Lets the reader and the color-classification path run on the FPGA without a physical sensor.

Parameters:
PERIOD_W, 24, width of per-channel half-period registers (clk cycles at 100% scale)
SETTLE_CYCLES, 1000, output-low cycles after any filter/scale change
RED_HP, 250, reset half-period for red channel
BLUE_HP, 200, reset half-period for blue channel
GREEN_HP, 300, reset half-period for green channel
CLEAR_HP, 80, reset half-period for clear channel

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scale  in  2  00 power-down, 01 2%, 10 20%, 11 100%
filter  in  2  00 red, 01 blue, 11 green, 10 clear
cfg_we  in  1  write strobe for half-period registers
cfg_sel  in  2  channel select for write, same encoding as filter
cfg_data  in  PERIOD_W  half-period value to write
sensorFreq  out  1  emulated sensor frequency output
settling  out  1  high while in SETTLE state
run  out  1  high while in RUN state

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - sensorFreq=0, run=0, settling=1.
  - Half-period registers take the *_HP parameters; counters are cleared.
  - filter_q/scale_q capture the input values.
  - State goes to SETTLE, or to OFF if scale==00.
- Input registers: filter_q and scale_q update every cycle. A change means {filter,scale} != {filter_q,scale_q} at a clock edge.
- States: OFF, SETTLE, RUN. Priority is reset > scale==00 > change > normal progression.
- OFF:
  - Entered on the edge where input scale==00, from any state.
  - sensorFreq=0 and all counters are held at 0.
  - When scale!=00, go to SETTLE on the next edge.
- SETTLE:
  - sensorFreq=0 and settle_cnt increments.
  - Any change restarts settle_cnt at 0.
  - When settle_cnt==SETTLE_CYCLES-1, go to RUN with half_cnt=0 and sensorFreq=0.
  - The active half-period (HP) is latched on RUN entry.
- RUN, counting: half_cnt counts 0..HP_eff-1. At HP_eff-1, sensorFreq toggles, half_cnt goes to 0, and HP_eff is reloaded from the current register for filter_q.
- RUN, transitions: any change goes to SETTLE on the same edge, with sensorFreq forced to 0 on that edge.
- Scaling rule:
  - HP_eff = HP*1 for scale 11, HP*5 for scale 10, HP*50 for scale 01.
  - Computed at PERIOD_W+6 bits, with no overflow possible.
  - Output period is 2*HP_eff cycles and the duty cycle is exactly 50%.
- HP==0 means no light: in RUN, sensorFreq is held 0 and half_cnt is held 0. The register is re-checked every cycle, so a nonzero write starts counting on the next edge.
- Latency: a filter/scale change at input edge N makes sensorFreq 0 from edge N. The first rising sensorFreq edge occurs SETTLE_CYCLES+HP_eff edges later.
- Config writes:
  - Take effect at the next toggle reload, or at RUN entry.
  - A write on the same edge as a reload is not seen by that reload; the old value is used and the new value applies from the following reload.
  - Writes are accepted in every state, including during reset deassertion cycles. Writes during reset itself are ignored.
- Reset mid-RUN: output drops to 0 on that edge; state re-enters SETTLE per the reset values above.
- Outputs are registered; there is no combinational path from inputs to sensorFreq.

Test Plan:
1. SETTLE_CYCLES=8, reset, scale=11, filter=00 (red, HP=250) -> sensorFreq rises at cycle 8+250 after reset release, then period 500, high exactly 250 cycles; 100 rising edges counted in 50000 cycles.
2. In RUN on red at scale 11, switch filter to 10 (clear, HP=80) -> sensorFreq 0 on same edge, settling=1 for 8 cycles, then period 160; change filter again at settle cycle 5 -> settle restarts, 8 full cycles.
3. Blue (HP=200) at scale 10 then 01 -> periods 2000 and 20000 cycles respectively; scale 00 -> sensorFreq 0, run=0, settling=0 next edge; scale back to 11 -> settle then period 400.
4. cfg write green=40 on the exact toggle edge while running green at scale 11 -> next half-period is 300, every later one is 40 (period 80).
5. cfg write red=0 while running red -> output freezes 0 after current half; write red=10 -> first toggle 10 cycles after write, period 20.
6. Assert reset for 1 cycle mid-high-phase -> sensorFreq 0 on that edge, registers restored to defaults (green back to 300), settle then red period 500.
